// File: rtl/demux1_to_2_16bit_stream.sv
// Registered 1-to-2 stream demultiplexer with packet-locked routing and a one-entry slot per output.
// Optional per-port delivered-beat counters are enabled by defining DEMUX_CNT_EN.
module demux_slot #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             dlast,
  input  logic             rdy,
  output logic             vld,
  output logic [WIDTH-1:0] data,
`ifdef DEMUX_CNT_EN
  output logic [CNT_W-1:0] cnt,
`endif
  output logic             last
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      data <= '0;
      last <= 1'b0;
    end else if (load) begin
      // a load wins over a same-cycle drain: slot stays full with the new beat
      vld  <= 1'b1;
      data <= din;
      last <= dlast;
    end else if (vld && rdy) begin
      vld  <= 1'b0;
    end
  end

`ifdef DEMUX_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            cnt <= '0;
    else if (vld && rdy && (cnt != '1))    cnt <= cnt + 1'b1;
  end
`endif
endmodule

module demux1_to_2_16bit_stream #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_last,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_last,
  output logic             out1_valid,
`ifdef DEMUX_CNT_EN
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
`endif
  input  logic             out1_ready
);
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t                  state, state_nx;
  logic                    esel, accept;
  logic [1:0]              load, ovld, olast, ordy;
  logic [1:0][WIDTH-1:0]   odata;
`ifdef DEMUX_CNT_EN
  logic [1:0][CNT_W-1:0]   ocnt;
`endif

  assign ordy = {out1_ready, out0_ready};

  // in_sel only matters on a first beat; locked states pin the destination
  always_comb begin
    esel = in_sel;
    case (state)
      LOCK0:   esel = 1'b0;
      LOCK1:   esel = 1'b1;
      default: esel = in_sel;
    endcase
  end

  assign in_ready = ~ovld[esel] | ordy[esel];
  assign accept   = in_valid & in_ready;
  assign load     = accept ? (esel ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && !in_last) state_nx = in_sel ? LOCK1 : LOCK0;
      LOCK0,
      LOCK1:   if (accept && in_last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  for (genvar p = 0; p < 2; p++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[p]),
      .din   (in_data),
      .dlast (in_last),
      .rdy   (ordy[p]),
      .vld   (ovld[p]),
      .data  (odata[p]),
`ifdef DEMUX_CNT_EN
      .cnt   (ocnt[p]),
`endif
      .last  (olast[p])
    );
  end

  assign out0_valid = ovld[0];
  assign out0_data  = odata[0];
  assign out0_last  = olast[0];
  assign out1_valid = ovld[1];
  assign out1_data  = odata[1];
  assign out1_last  = olast[1];
`ifdef DEMUX_CNT_EN
  assign cnt0 = ocnt[0];
  assign cnt1 = ocnt[1];
`endif
endmodule

// File: tb/tb_demux1_to_2_16bit_stream.sv
// Bench for demux1_to_2_16bit_stream: directed scenarios plus random traffic checked
// against a queue-based model of packet routing and one-entry output buffers.
module tb_demux1_to_2_16bit_stream;
  localparam int WIDTH = 16;
`ifdef DEMUX_CNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 8;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_sel, in_last, in_valid, in_ready;
  logic [WIDTH-1:0] out0_data, out1_data;
  logic             out0_last, out1_last, out0_valid, out1_valid;
  logic             out0_ready, out1_ready;
`ifdef DEMUX_CNT_EN
  logic [CW-1:0]    cnt0, cnt1;
`endif

  demux1_to_2_16bit_stream #(.WIDTH(WIDTH), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_last    (in_last),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_last  (out0_last),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_last  (out1_last),
    .out1_valid (out1_valid),
`ifdef DEMUX_CNT_EN
    .cnt0       (cnt0),
    .cnt1       (cnt1),
`endif
    .out1_ready (out1_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: pending beats per port as {last, data}; packet routing memory
  logic [WIDTH:0] q0[$];
  logic [WIDTH:0] q1[$];
  logic           in_pkt;
  logic           cur_dest;
  int             mc0, mc1;
  logic           seen_rdy;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    in_pkt = 1'b0;
    cur_dest = 1'b0;
    mc0 = 0;
    mc1 = 0;
  endtask

  task automatic check_outputs();
    chk("out0_valid", 32'(out0_valid), 32'(q0.size() > 0));
    chk("out1_valid", 32'(out1_valid), 32'(q1.size() > 0));
    if (q0.size() > 0) begin
      chk("out0_data", 32'(out0_data), 32'(q0[0][WIDTH-1:0]));
      chk("out0_last", 32'(out0_last), 32'(q0[0][WIDTH]));
    end
    if (q1.size() > 0) begin
      chk("out1_data", 32'(out1_data), 32'(q1[0][WIDTH-1:0]));
      chk("out1_last", 32'(out1_last), 32'(q1[0][WIDTH]));
    end
`ifdef DEMUX_CNT_EN
    chk("cnt0", 32'(cnt0), 32'(mc0));
    chk("cnt1", 32'(cnt1), 32'(mc1));
`endif
  endtask

  // called at a negedge: drive one cycle, check in_ready, advance model at posedge, check outputs
  task automatic step(input logic v, input logic s, input logic l, input logic [WIDTH-1:0] d,
                      input logic r0, input logic r1);
    logic dest, exp_rdy, acc, dr0, dr1;
    int   sat;
    in_valid = v; in_sel = s; in_last = l; in_data = d;
    out0_ready = r0; out1_ready = r1;
    #1;
    dest    = in_pkt ? cur_dest : s;
    exp_rdy = dest ? ((q1.size() == 0) || r1) : ((q0.size() == 0) || r0);
    seen_rdy = in_ready;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk);
    sat = (1 << CW) - 1;
    dr0 = (q0.size() > 0) && r0;
    dr1 = (q1.size() > 0) && r1;
    if (dr0) begin void'(q0.pop_front()); if (mc0 < sat) mc0++; end
    if (dr1) begin void'(q1.pop_front()); if (mc1 < sat) mc1++; end
    if (acc) begin
      if (dest) q1.push_back({l, d}); else q0.push_back({l, d});
      if (!in_pkt && !l) begin in_pkt = 1'b1; cur_dest = s; end
      else if (in_pkt && l) in_pkt = 1'b0;
    end
    @(negedge clk);
    check_outputs();
  endtask

  // asynchronous reset asserted mid-cycle; returns at a negedge with rst_n released
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst out0_valid", 32'(out0_valid), 32'd0);
    chk("rst out1_valid", 32'(out1_valid), 32'd0);
    chk("rst out0_data", 32'(out0_data), 32'd0);
    chk("rst out1_data", 32'(out1_data), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_sel = 1'b0; in_last = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    model_reset();
    #1;
    chk("reset out0_valid", 32'(out0_valid), 32'd0);
    chk("reset out1_valid", 32'(out1_valid), 32'd0);
    chk("reset out0_data", 32'(out0_data), 32'd0);
    chk("reset out1_last", 32'(out1_last), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
`ifdef DEMUX_CNT_EN
    chk("reset cnt0", 32'(cnt0), 32'd0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // single-beat packet to port 1
    step(1, 1, 1, 16'd5, 0, 1);
    chk("single out1_valid", 32'(out1_valid), 32'd1);
    chk("single out1_data", 32'(out1_data), 32'd5);
    chk("single out0_valid", 32'(out0_valid), 32'd0);

    // packet lock: sel toggles mid-packet, all beats stay on port 0
    step(1, 0, 0, 16'd6, 1, 1);
    chk("lock b1 out0_data", 32'(out0_data), 32'd6);
    chk("lock b1 out0_last", 32'(out0_last), 32'd0);
    step(1, 1, 0, 16'd7, 1, 1);
    chk("lock b2 out0_data", 32'(out0_data), 32'd7);
    chk("lock b2 out1_valid", 32'(out1_valid), 32'd0);
    step(1, 1, 1, 16'd8, 1, 1);
    chk("lock b3 out0_data", 32'(out0_data), 32'd8);
    chk("lock b3 out0_last", 32'(out0_last), 32'd1);
    chk("lock b3 out1_valid", 32'(out1_valid), 32'd0);
    step(0, 0, 0, 16'd0, 1, 1);

    // backpressure on port 0
    step(1, 0, 1, 16'hA0A0, 0, 1);
    chk("bp first held", 32'(out0_data), 32'hA0A0);
    step(1, 0, 1, 16'hB0B0, 0, 1);
    chk("bp in_ready low", 32'(seen_rdy), 32'd0);
    chk("bp first stable", 32'(out0_data), 32'hA0A0);
    step(1, 0, 1, 16'hB0B0, 1, 1);
    chk("bp in_ready on drain", 32'(seen_rdy), 32'd1);
    chk("bp second loaded", 32'(out0_data), 32'hB0B0);
    chk("bp still valid", 32'(out0_valid), 32'd1);
    step(0, 0, 0, 16'd0, 1, 1);

    // independent drain: port 1 stalled, port 0 still flows
    step(1, 1, 1, 16'hC1C1, 1, 0);
    step(1, 0, 1, 16'hD0D0, 1, 0);
    chk("indep in_ready", 32'(seen_rdy), 32'd1);
    chk("indep out0_data", 32'(out0_data), 32'hD0D0);
    chk("indep out1_data", 32'(out1_data), 32'hC1C1);
    step(0, 0, 0, 16'd0, 1, 1);

    // mid-packet reset on a port-1 packet
    step(1, 1, 0, 16'hE1E1, 1, 0);
    do_reset();
    step(1, 0, 1, 16'hF0F0, 1, 1);
    chk("post-reset routes to 0", 32'(out0_valid), 32'd1);
    chk("post-reset out0_data", 32'(out0_data), 32'hF0F0);
    chk("post-reset out1_valid", 32'(out1_valid), 32'd0);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 16'(i + 1), 1, 1);
    step(0, 0, 0, 16'd0, 1, 1);
`ifdef DEMUX_CNT_EN
    chk("cnt0 saturated", 32'(cnt0), 32'd3);
    chk("cnt1 idle", 32'(cnt1), 32'd0);
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) == 0,
           16'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux1_to_2_16bit_stream.md
# demux1_to_2_16bit_stream

Registered 1-to-2 stream demultiplexer. It takes one 16-bit valid/ready input stream and steers each packet to one of two output ports, each with its own valid/ready handshake. The port is chosen by a select bit captured on a packet's first beat and held until its last beat. It is the distribution end of the datapath selection that `mux2_to_1_16bit` performs, and it feeds two downstream consumers (e.g. ALU and register-write paths) from a single producer.

## Interface
- `WIDTH`, 16, data width of input and both outputs.
- `CNT_W`, 8, width of per-output beat counters (only with `DEMUX_CNT_EN`).

- `clk`  input  1  single clock; all state on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_data`  input  WIDTH  input beat payload.
- `in_sel`  input  1  destination: 0 → port 0, 1 → port 1; sampled only on a packet's first beat.
- `in_last`  input  1  marks the final beat of a packet.
- `in_valid`  input  1  producer has a beat.
- `in_ready`  output  1  block accepts the beat this cycle.
- `out0_data`, `out1_data`  output  WIDTH  registered payloads.
- `out0_last`, `out1_last`  output  1  registered last flags.
- `out0_valid`, `out1_valid`  output  1  slot holds a beat.
- `out0_ready`, `out1_ready`  input  1  consumer takes the beat.
- `cnt0`, `cnt1`  output  CNT_W  beats delivered per port (only with `DEMUX_CNT_EN`).

## Operation
- Route FSM states: IDLE, LOCK0, LOCK1. Reset → IDLE.
- Effective select `esel`: equals `in_sel` in IDLE, 0 in LOCK0, 1 in LOCK1.
- Accept = `in_valid && in_ready`.
- Transitions:
  - IDLE → LOCKn on an accepted beat with `in_last`=0, where n = `in_sel`.
  - LOCKn → IDLE on an accepted beat with `in_last`=1.
  - Otherwise hold.
  - IDLE stays IDLE on an accepted single-beat packet (`in_last`=1).
- Each output has a one-entry slot (EMPTY/FULL, flagged by `outN_valid`).
- `in_ready` = slot[esel] empty OR `outN_ready` of slot[esel] asserted. Combinational from `outN_ready`; no combinational path from `in_valid`.
- On accept: slot[esel] loads `in_data` and `in_last`, and its valid is set.
- A slot clears when `outN_valid && outN_ready` and no simultaneous load.
- Simultaneous drain and load of the same slot: slot stays FULL with the new beat.
- The non-selected slot is never disturbed. Both slots may drain in the same cycle.
- `in_sel` changes mid-packet are ignored.
- `outN_data` holds its value while `outN_valid`=1 and `outN_ready`=0.

## Timing
- Latency: beat accepted at edge k appears on `outN_*` with valid=1 immediately after edge k (one register stage).
- Full throughput: one beat per cycle per port while the consumer holds ready=1.
- Reset values (async, immediate on `rst_n`=0):
  - FSM IDLE.
  - `out0_valid`, `out1_valid` = 0.
  - `out0_data`, `out1_data` = 0.
  - `out0_last`, `out1_last` = 0.
  - `cnt0`, `cnt1` = 0.
- `in_ready` is 1 out of reset, because both slots are empty.
- Reset mid-packet: packet state is discarded and the FSM returns to IDLE. The next beat after reset release is treated as a first beat.
- Reset release is synchronous in effect: no accepts on the first edge where `rst_n` has just risen is not required. Normal operation starts on the first edge with `rst_n`=1.

## Configuration
- `DEMUX_CNT_EN` defined:
  - `cnt0`/`cnt1` are present.
  - Each increments by 1 on every `outN_valid && outN_ready` handshake.
  - Each saturates at 2^CNT_W−1 (no wrap).
- `DEMUX_CNT_EN` undefined:
  - Counter ports and logic are removed.
  - All other behaviour is identical.

## Test plan
- Reset then single beat: `in_data`=16'd5, `in_sel`=1, `in_last`=1, `out1_ready`=1 → `out1_valid`=1 with 16'd5 the next cycle; `out0_valid` stays 0; FSM stays IDLE.
- Packet lock: 3-beat packet (16'd6, 16'd7, 16'd8), `in_sel`=0 on beat 1, `in_sel` toggled to 1 on beats 2–3 → all three beats appear on port 0, with `out0_last`=1 only on 16'd8.
- Backpressure: `out0_ready`=0, send two beats to port 0 → first beat is held stable, `in_ready`=0 on the second; raising `out0_ready` accepts the second beat the same cycle the first drains.
- Independent drain: fill port 1 with `out1_ready`=0, then send a single-beat packet to port 0 → accepted with `in_ready`=1; port 1 data stays unchanged.
- Mid-packet reset: assert `rst_n`=0 after beat 1 of a port-1 packet → valids and data go to 0 immediately; after release, a beat with `in_sel`=0 routes to port 0.
- With `DEMUX_CNT_EN`, `CNT_W`=2: deliver 5 beats to port 0 → `cnt0` saturates at 3 and `cnt1` stays 0.
